// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite commit controller.
//   sprite_entry_t  - one sprite table entry {x, y, en, animate, frame}
//   FIELD_*         - register field selector values (address[5:4])
//   COMMIT_ADDR     - Avalon word address of the commit request register
//   commit_state_e  - commit FSM state encoding
package sprite_pkg;

    localparam int MAX_SPRITES = 16;

    localparam logic [1:0] FIELD_X    = 2'd0;
    localparam logic [1:0] FIELD_Y    = 2'd1;
    localparam logic [1:0] FIELD_CTRL = 2'd2;

    localparam logic [2:0] SHADOW_PAGE = 3'b000;
    localparam logic [8:0] COMMIT_ADDR = 9'h040;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        en;
        logic        animate;
        logic [1:0]  frame;
    } sprite_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } commit_state_e;

endpackage

// File: rtl/anim_ticker.sv
// anim_ticker: animation phase generator.
//   A down-counter divider raises tick_pending every ANIM_DIV clk cycles.
//   anim_phase_o advances (mod ANIM_FRAMES) only on vblank_start while a tick
//   is pending, so the visible phase never changes mid-frame and several ticks
//   between two vblanks still advance it only once.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   vblank_start      - one-cycle pulse at the first blanked line
//   anim_phase_o[1:0] - current animation phase
// Only instantiated when SPRITE_ANIM_EN is defined.
module anim_ticker #(
    parameter int ANIM_DIV    = 5_000_000,
    parameter int ANIM_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vblank_start,
    output logic [1:0] anim_phase_o
);

    localparam int                DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(ANIM_DIV - 1);
    localparam logic [1:0]        LAST_PHASE = 2'(ANIM_FRAMES - 1);

    logic [DIV_W-1:0] div_q;
    logic             tick_pending_q;
    logic [1:0]       phase_q;
    logic             tick;
    logic             advance;

    assign tick    = (div_q == '0);
    assign advance = vblank_start && tick_pending_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= DIV_RELOAD;
        end else if (tick) begin
            div_q <= DIV_RELOAD;
        end else begin
            div_q <= div_q - 1'b1;
        end
    end

    // A tick landing in the same cycle as the consuming vblank stays pending
    // for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_pending_q <= 1'b0;
        end else if (tick) begin
            tick_pending_q <= 1'b1;
        end else if (advance) begin
            tick_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 2'd0;
        end else if (advance) begin
            phase_q <= (phase_q == LAST_PHASE) ? 2'd0 : phase_q + 2'd1;
        end
    end

    assign anim_phase_o = phase_q;

endmodule

// File: rtl/sprite_commit_ctrl.sv
// sprite_commit_ctrl: double-buffered sprite table with vblank-synchronous commit.
//   Software writes the shadow bank over Avalon-MM at any time. A commit request
//   arms the controller; at the next vblank_start the shadow bank is copied into
//   the active bank one entry per cycle. The display reads the active bank
//   combinationally through rd_idx.
// Ports:
//   clk, reset                          - clock, asynchronous active-high reset
//   chipselect, write, address, writedata - Avalon-MM write slave
//   vblank_start                        - one-cycle pulse at the first blanked line
//   rd_idx -> rd_x, rd_y, rd_en, rd_frame - active bank read port
//   commit_pending, busy                - commit status
//   anim_phase                          - animation phase (0 unless animated)
//   commit_count                        - completed copies, wraps at 16 bits
// Build option: define SPRITE_ANIM_EN to include the anim_ticker phase generator.
//
// State  | meaning
// IDLE   | no commit outstanding, vblank ignored
// ARMED  | commit requested, waiting for vblank_start
// COPY   | copying shadow[copy_idx] -> active[copy_idx], one entry per cycle
module sprite_commit_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 16,
    parameter int ANIM_DIV    = 5_000_000,
    parameter int ANIM_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [8:0]  address,
    input  logic [31:0] writedata,
    input  logic        vblank_start,
    input  logic [3:0]  rd_idx,
    output logic [10:0] rd_x,
    output logic [9:0]  rd_y,
    output logic        rd_en,
    output logic [1:0]  rd_frame,
    output logic        commit_pending,
    output logic        busy,
    output logic [1:0]  anim_phase,
    output logic [15:0] commit_count
);

    if (NUM_SPRITES < 1 || NUM_SPRITES > MAX_SPRITES || ANIM_DIV < 1 ||
        ANIM_FRAMES < 2 || ANIM_FRAMES > 4) begin : g_param_check
        $error("sprite_commit_ctrl: parameter out of range");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_SPRITES - 1);
    localparam logic [4:0] NUM_W    = 5'(NUM_SPRITES);

    // Banks are sized for the maximum table; entries above NUM_SPRITES are
    // never written and stay at their reset value.
    sprite_entry_t shadow_q [MAX_SPRITES];
    sprite_entry_t active_q [MAX_SPRITES];

    commit_state_e state_q, state_d;
    logic [3:0]    copy_idx_q, copy_idx_d;
    logic          rearm_q, rearm_d;
    logic [15:0]   commit_count_q;
    logic          copy_en;
    logic          copy_last;

    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [1:0]    wr_field;
    logic          shadow_we;
    logic          commit_req;
    logic          unused_wd;
    logic [1:0]    anim_phase_w;
    logic          rd_valid;
    sprite_entry_t rd_entry;

    assign wr_en      = chipselect && write;
    assign wr_idx     = address[3:0];
    assign wr_field   = address[5:4];
    assign shadow_we  = wr_en && (address[8:6] == SHADOW_PAGE) && ({1'b0, wr_idx} < NUM_W);
    assign commit_req = wr_en && (address == COMMIT_ADDR) && writedata[0];
    assign unused_wd  = ^writedata[31:11];

    // Shadow bank: always writable, no backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (shadow_we) begin
            case (wr_field)
                FIELD_X:    shadow_q[wr_idx].x <= writedata[10:0];
                FIELD_Y:    shadow_q[wr_idx].y <= writedata[9:0];
                FIELD_CTRL: begin
                    shadow_q[wr_idx].en      <= writedata[0];
                    shadow_q[wr_idx].frame   <= writedata[2:1];
                    shadow_q[wr_idx].animate <= writedata[3];
                end
                default: ;
            endcase
        end
    end

    // Copy reads the registered shadow entry, so a same-cycle write to the
    // entry being copied lands in shadow only and the old value is copied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                active_q[i] <= '0;
            end
        end else if (copy_en) begin
            active_q[copy_idx_q] <= shadow_q[copy_idx_q];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            copy_idx_q <= 4'd0;
            rearm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            copy_idx_q <= copy_idx_d;
            rearm_q    <= rearm_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d    = state_q;
        copy_idx_d = copy_idx_q;
        rearm_d    = rearm_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (vblank_start) begin
                    state_d    = ST_COPY;
                    copy_idx_d = 4'd0;
                end
            end
            ST_COPY: begin
                copy_idx_d = copy_idx_q + 4'd1;
                if (commit_req) rearm_d = 1'b1;
                if (copy_idx_q == LAST_IDX) begin
                    // A request arriving on the final copy cycle also re-arms.
                    state_d    = (rearm_q || commit_req) ? ST_ARMED : ST_IDLE;
                    rearm_d    = 1'b0;
                    copy_idx_d = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        copy_en        = (state_q == ST_COPY);
        copy_last      = copy_en && (copy_idx_q == LAST_IDX);
        busy           = copy_en;
        commit_pending = (state_q == ST_ARMED) || rearm_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count_q <= 16'd0;
        end else if (copy_last) begin
            commit_count_q <= commit_count_q + 16'd1;
        end
    end

    assign commit_count = commit_count_q;

`ifdef SPRITE_ANIM_EN
    anim_ticker #(
        .ANIM_DIV    (ANIM_DIV),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_anim_ticker (
        .clk          (clk),
        .reset        (reset),
        .vblank_start (vblank_start),
        .anim_phase_o (anim_phase_w)
    );
`else
    assign anim_phase_w = 2'd0;
`endif

    assign anim_phase = anim_phase_w;

    assign rd_valid = ({1'b0, rd_idx} < NUM_W);
    assign rd_entry = rd_valid ? active_q[rd_idx] : '0;
    assign rd_x     = rd_entry.x;
    assign rd_y     = rd_entry.y;
    assign rd_en    = rd_entry.en;
    assign rd_frame = rd_entry.animate ? anim_phase_w : rd_entry.frame;

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
module tb_sprite_commit_ctrl;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic        vblank_start;
    logic [3:0]  rd_idx;
    logic [10:0] rd_x;
    logic [9:0]  rd_y;
    logic        rd_en;
    logic [1:0]  rd_frame;
    logic        commit_pending;
    logic        busy;
    logic [1:0]  anim_phase;
    logic [15:0] commit_count;

    int checks = 0;
    int errors = 0;

    sprite_commit_ctrl #(
        .NUM_SPRITES (16),
        .ANIM_DIV    (10),
        .ANIM_FRAMES (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .chipselect     (chipselect),
        .write          (write),
        .address        (address),
        .writedata      (writedata),
        .vblank_start   (vblank_start),
        .rd_idx         (rd_idx),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_en          (rd_en),
        .rd_frame       (rd_frame),
        .commit_pending (commit_pending),
        .busy           (busy),
        .anim_phase     (anim_phase),
        .commit_count   (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic bus(input logic [8:0] a, input logic [31:0] d, input logic wr, input logic vb);
        chipselect   = wr;
        write        = wr;
        address      = a;
        writedata    = d;
        vblank_start = vb;
        @(negedge clk);
        chipselect   = 1'b0;
        write        = 1'b0;
        vblank_start = 1'b0;
    endtask

    task automatic wr_reg(input logic [8:0] a, input logic [31:0] d);
        bus(a, d, 1'b1, 1'b0);
    endtask

    task automatic vblank();
        bus(9'h000, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_copy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] idx,
                          input logic [10:0] ex, input logic [9:0] ey, input logic een);
        rd_idx = idx;
        #1;
        chk({tag, "_x"}, 32'(rd_x), 32'(ex));
        chk({tag, "_y"}, 32'(rd_y), 32'(ey));
        chk({tag, "_en"}, 32'(rd_en), 32'(een));
    endtask

    int n;
    int n2;
    logic [1:0] exp_ph [4];

    initial begin
        reset        = 1'b1;
        chipselect   = 1'b0;
        write        = 1'b0;
        address      = 9'h000;
        writedata    = 32'd0;
        vblank_start = 1'b0;
        rd_idx       = 4'd0;
`ifdef SPRITE_ANIM_EN
        exp_ph[0] = 2'd0; exp_ph[1] = 2'd1; exp_ph[2] = 2'd2; exp_ph[3] = 2'd0;
`else
        exp_ph[0] = 2'd0; exp_ph[1] = 2'd0; exp_ph[2] = 2'd0; exp_ph[3] = 2'd0;
`endif
        idle(3);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_pending", 32'(commit_pending), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(commit_count), 0);

        // Basic commit: idx 2 x=300 y=150 en=1
        wr_reg(9'h002, 32'd300);
        wr_reg(9'h012, 32'd150);
        wr_reg(9'h022, 32'd1);
        wr_reg(9'h082, 32'd5);        // upper page, must be ignored
        wr_reg(9'h040, 32'd0);        // commit address with bit0=0: no commit
        chk("nocommit_pending", 32'(commit_pending), 0);
        chk_rd("pre_commit", 4'd2, 11'd0, 10'd0, 1'b0);
        vblank();                      // vblank in IDLE is ignored
        chk("idle_vblank_busy", 32'(busy), 0);
        wr_reg(9'h040, 32'd1);
        chk("armed_pending", 32'(commit_pending), 1);
        chk("armed_busy", 32'(busy), 0);
        vblank();
        wait_copy(n);
        chk("copy1_cycles", 32'(n), 16);
        chk_rd("copy1", 4'd2, 11'd300, 10'd150, 1'b1);
        chk("copy1_frame", 32'(rd_frame), 0);
        chk("copy1_count", 32'(commit_count), 1);
        chk("copy1_pending", 32'(commit_pending), 0);

        // Commit and vblank in the same cycle: arm only
        bus(9'h040, 32'd1, 1'b1, 1'b1);
        chk("coinc_pending", 32'(commit_pending), 1);
        chk("coinc_busy", 32'(busy), 0);
        idle(2);
        chk("coinc_busy_later", 32'(busy), 0);
        vblank();
        wait_copy(n);
        chk("coinc_cycles", 32'(n), 16);
        chk("coinc_count", 32'(commit_count), 2);

        // Collision during copy at idx 5
        wr_reg(9'h005, 32'd33);
        wr_reg(9'h040, 32'd1);
        vblank();
        wait_copy(n);
        chk_rd("idx5_setup", 4'd5, 11'd33, 10'd0, 1'b0);
        wr_reg(9'h040, 32'd1);
        vblank();
        idle(5);                       // next edge copies idx 5
        wr_reg(9'h005, 32'd77);
        wait_copy(n);
        chk("collide_cycles", 32'(n + 6), 16);
        chk_rd("collide_old", 4'd5, 11'd33, 10'd0, 1'b0);
        chk("collide_count", 32'(commit_count), 4);
        wr_reg(9'h040, 32'd1);
        vblank();
        wait_copy(n);
        chk_rd("collide_new", 4'd5, 11'd77, 10'd0, 1'b0);
        chk("collide2_count", 32'(commit_count), 5);

        // Commit during copy re-arms
        wr_reg(9'h012, 32'd9);
        wr_reg(9'h040, 32'd1);
        vblank();
        idle(3);
        wr_reg(9'h040, 32'd1);
        chk("rearm_pending_in_copy", 32'(commit_pending), 1);
        chk("rearm_busy_in_copy", 32'(busy), 1);
        wait_copy(n);
        chk("rearm_pending", 32'(commit_pending), 1);
        chk("rearm_busy", 32'(busy), 0);
        chk("rearm_count", 32'(commit_count), 6);
        chk_rd("rearm_y", 4'd2, 11'd300, 10'd9, 1'b1);
        vblank();
        wait_copy(n2);
        chk("rearm_copy_cycles", 32'(n2), 16);
        chk("rearm_count2", 32'(commit_count), 7);
        chk("rearm_pending_done", 32'(commit_pending), 0);

        // Reset mid-copy at idx 8
        wr_reg(9'h008, 32'd500);
        wr_reg(9'h040, 32'd1);
        vblank();
        idle(8);
        reset = 1'b1;
        #1;
        chk_rd("rst_mid_idx2", 4'd2, 11'd0, 10'd0, 1'b0);
        chk_rd("rst_mid_idx8", 4'd8, 11'd0, 10'd0, 1'b0);
        chk("rst_mid_frame", 32'(rd_frame), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_pending", 32'(commit_pending), 0);
        chk("rst_mid_count", 32'(commit_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Animation: idx 0 animate=1 en=1 frame=2, committed before first tick
        wr_reg(9'h020, 32'hD);
        wr_reg(9'h040, 32'd1);
        vblank();
        wait_copy(n);
        rd_idx = 4'd0;
        #1;
        chk("anim_en", 32'(rd_en), 1);
        for (int k = 0; k < 4; k++) begin
            rd_idx = 4'd0;
            #1;
            chk($sformatf("anim_frame%0d", k), 32'(rd_frame), 32'(exp_ph[k]));
            @(negedge clk);
            vblank();
            idle(23);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_commit_ctrl.md
SPRITE_COMMIT_CTRL -- requirements
Module: sprite_commit_ctrl

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 16: number of sprite entries (power of two, max 16).
REQ-002 SHALL have parameter ANIM_DIV, default 5_000_000: clk cycles per animation tick.
REQ-003 SHALL have parameter ANIM_FRAMES, default 3: animation phase modulus (2..4).
REQ-004 SHALL have ports: clk input 1 (system clock) and reset input 1 (asynchronous, active-high).
REQ-005 SHALL have ports: chipselect input 1, write input 1, address input 9, writedata input 32 (Avalon-MM write slave).
REQ-006 SHALL have port: vblank_start input 1, one-cycle pulse at the first blanked line.
REQ-007 SHALL have ports: rd_idx input 4, rd_x output 11, rd_y output 10, rd_en output 1, rd_frame output 2 (combinational read of the active bank).
REQ-008 SHALL have ports: commit_pending output 1, busy output 1, anim_phase output 2, commit_count output 16.

Function
REQ-009 SHALL keep a shadow bank and an active bank, each NUM_SPRITES entries {x[10:0], y[9:0], en, animate, frame[1:0]}.
REQ-010 SHALL decode a write (chipselect && write) as: address[8:6]=0, idx=address[3:0], field=address[5:4]; 0 = x<=wd[10:0], 1 = y<=wd[9:0], 2 = ctrl {frame=wd[2:1], animate=wd[3], en=wd[0]}, 3 = ignored.
REQ-011 SHALL treat address 9'h040 with wd[0]=1 as a commit request; all other addresses, and idx>=NUM_SPRITES, are ignored.
REQ-012 SHALL accept shadow writes every cycle in every state, with no backpressure.
REQ-013 SHALL implement FSM IDLE/ARMED/COPY: IDLE->ARMED on commit request; ARMED->COPY on vblank_start; COPY->IDLE after the last entry is copied.
REQ-014 SHALL, in COPY, copy one entry per cycle (shadow[i]->active[i], i = 0..NUM_SPRITES-1), taking NUM_SPRITES cycles.
REQ-015 SHALL, when a commit request and vblank_start coincide in IDLE, go to ARMED only; the copy starts at the next vblank_start.
REQ-016 SHALL, on a commit request during COPY, set a re-arm flag; COPY then exits to ARMED instead of IDLE.
REQ-017 SHALL, when a shadow write hits the entry being copied in the same cycle, copy the pre-write value; the new value stays in the shadow bank.
REQ-018 SHALL drive commit_pending=1 in ARMED or when the re-arm flag is set, and busy=1 in COPY.
REQ-019 SHALL increment commit_count (wrapping 16'hFFFF->0) in the cycle the last entry is copied.
REQ-020 SHALL drive rd_frame = animate ? anim_phase : frame, and output zeros for rd_idx>=NUM_SPRITES.
REQ-021 SHALL ignore vblank_start in IDLE and COPY.

Reset
REQ-022 SHALL, on reset, clear both banks (x=0, y=0, en=0, animate=0, frame=0), set state IDLE, clear the re-arm flag, and clear commit_count, anim_phase and the divider.
REQ-023 SHALL, on reset mid-COPY, abort the copy immediately; the active bank is zero after reset.

Configuration
REQ-024 SHALL, with SPRITE_ANIM_EN defined, run a divider that sets tick_pending every ANIM_DIV cycles; anim_phase advances (mod ANIM_FRAMES) only on vblank_start while tick_pending=1, which clears tick_pending; multiple ticks between vblanks advance the phase once.
REQ-025 SHALL, without SPRITE_ANIM_EN, build no divider and hold anim_phase constant 0.

Structure
REQ-026 SHALL keep sprite_entry_t, the field and address constants and COMMIT_ADDR in shared package sprite_pkg.
REQ-027 SHALL place the divider and phase logic in sub-module anim_ticker, instantiated only under SPRITE_ANIM_EN.

Verification
REQ-028 Write idx 2: x=300, y=150, ctrl=1; read rd_idx=2 -> 0,0,0; commit, then vblank_start -> after 16 cycles rd = 300/150/en=1, commit_count=1.
REQ-029 Commit request and vblank_start in the same cycle -> commit_pending=1, busy=0; next vblank_start -> busy for exactly 16 cycles.
REQ-030 During COPY at i=5, write x=77 to idx 5 -> active x=old value, shadow x=77; a second commit then lands 77.
REQ-031 Commit during COPY -> ends in ARMED, commit_pending=1, commit_count increments once per copy.
REQ-032 SPRITE_ANIM_EN, ANIM_DIV=10, animate=1, vblank every 25 cycles -> rd_frame 0,1,2,0 at successive vblanks; without the macro, always 0.
REQ-033 Assert reset at COPY i=8 -> all rd outputs 0, state IDLE, commit_count=0.
